pdp8_trace: RTL and testbench

- Hardware instruction-trace capture unit that sits directly downstream of the pdp8 CPU core in top.
- Samples PC/IR/L/AC/ION at every fetch into a circular on-chip buffer, with an optional PC-match trigger and a post-trigger record count.
- On request, dumps the buffer oldest-first as octal ASCII lines through a byte handshake into the UART transmitter.
- Gives silicon runs the same trace a simulation bench prints, without a simulator.

---
 rtl/pdp8_trace.sv | 207 ++++++++++++++++++++
 tb/tb_pdp8_trace.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pdp8_trace.sv
// PDP-8 instruction-trace capture unit: circular record buffer with
// PC-match trigger, post-trigger count and an octal ASCII dump.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   arm, disarm           start capture / stop capture (contents kept)
//   fetch_strobe          one pulse per fetch; pc/ir/l/ac/ion sampled
//   trig_en, trig_pc      PC-match trigger
//   dump_req              start dumping the buffer oldest-first
//   tx_data/valid/ready   byte handshake towards the UART
//   busy, done            status: capturing/dumping, capture finished
//   triggered             trigger seen since last arm
//   count                 valid records, saturates at 2**ADDR_W
module pdp8_trace #(
    parameter int ADDR_W   = 8,
    parameter int POST_CNT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              arm,
    input  logic              disarm,
    input  logic              fetch_strobe,
    input  logic [11:0]       pc,
    input  logic [11:0]       ir,
    input  logic              l,
    input  logic [11:0]       ac,
    input  logic              ion,
    input  logic              trig_en,
    input  logic [11:0]       trig_pc,
    input  logic              dump_req,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic              triggered,
    output logic [ADDR_W:0]   count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] POST_C  = ADDR_W'(POST_CNT);
    localparam bit NO_POST = (POST_CNT == 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_POST,
        S_DONE,
        S_DUMP_RD,
        S_DUMP_TX
    } state_t;

    state_t state, state_n;

    logic [37:0]       mem [DEPTH];
    logic [37:0]       rd_q;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] post_cnt;
    logic [ADDR_W:0]   rem;
    logic [4:0]        byte_idx;

    logic we;
    logic hit;
    logic xfer;
    logic last_byte;
    logic start_arm;
    logic start_dump;
    logic idle_or_done;

    assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
    assign start_arm    = idle_or_done && arm;
    // arm wins over dump_req; an empty buffer has nothing to dump
    assign start_dump   = idle_or_done && !arm && dump_req
                          && (count != '0);
    assign we   = fetch_strobe && ((state == S_ARMED) || (state == S_POST));
    assign hit  = fetch_strobe && trig_en && (pc == trig_pc)
                  && (state == S_ARMED);
    assign xfer = (state == S_DUMP_TX) && tx_ready;
    assign last_byte = (byte_idx == 5'd19);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_arm)       state_n = S_ARMED;
                else if (start_dump) state_n = S_DUMP_RD;
            end
            S_ARMED: begin
                if (disarm)   state_n = S_DONE;
                else if (hit) state_n = NO_POST ? S_DONE : S_POST;
            end
            S_POST: begin
                if (disarm || (fetch_strobe && post_cnt == ADDR_W'(1)))
                    state_n = S_DONE;
            end
            S_DUMP_RD: state_n = S_DUMP_TX;
            S_DUMP_TX: begin
                if (xfer && last_byte)
                    state_n = (rem == (ADDR_W+1)'(1)) ? S_IDLE : S_DUMP_RD;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            triggered <= 1'b0;
            rd_ptr    <= '0;
            rem       <= '0;
            byte_idx  <= '0;
        end else begin
            if (start_arm) begin
                wr_ptr    <= '0;
                count     <= '0;
                post_cnt  <= '0;
                triggered <= 1'b0;
            end
            if (we) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (count != DEPTH_C) count <= count + 1'b1;
            end
            if (hit) begin
                triggered <= 1'b1;
                post_cnt  <= POST_C;
            end
            if (state == S_POST && fetch_strobe && post_cnt != '0)
                post_cnt <= post_cnt - 1'b1;
            if (start_dump) begin
                // a full buffer gives low bits 0, so rd_ptr lands on wr_ptr
                rd_ptr   <= wr_ptr - count[ADDR_W-1:0];
                rem      <= count;
                byte_idx <= '0;
            end
            if (xfer) begin
                if (last_byte) begin
                    byte_idx <= '0;
                    rd_ptr   <= rd_ptr + 1'b1;
                    rem      <= rem - 1'b1;
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr] <= {pc, ir, l, ac, ion};
        if (state == S_DUMP_RD) rd_q <= mem[rd_ptr];
    end

    logic [11:0] r_pc;
    logic [11:0] r_ir;
    logic [11:0] r_ac;
    logic        r_l;
    logic        r_ion;

    assign r_pc  = rd_q[37:26];
    assign r_ir  = rd_q[25:14];
    assign r_l   = rd_q[13];
    assign r_ac  = rd_q[12:1];
    assign r_ion = rd_q[0];

    function automatic logic [7:0] oct(input logic [2:0] f);
        return {5'b00110, f};
    endfunction

    always_comb begin
        tx_data = 8'h00;
        if (state == S_DUMP_TX) begin
            case (byte_idx)
                5'd0:  tx_data = oct(r_pc[11:9]);
                5'd1:  tx_data = oct(r_pc[8:6]);
                5'd2:  tx_data = oct(r_pc[5:3]);
                5'd3:  tx_data = oct(r_pc[2:0]);
                5'd5:  tx_data = oct(r_ir[11:9]);
                5'd6:  tx_data = oct(r_ir[8:6]);
                5'd7:  tx_data = oct(r_ir[5:3]);
                5'd8:  tx_data = oct(r_ir[2:0]);
                5'd10: tx_data = oct({2'b00, r_l});
                5'd12: tx_data = oct(r_ac[11:9]);
                5'd13: tx_data = oct(r_ac[8:6]);
                5'd14: tx_data = oct(r_ac[5:3]);
                5'd15: tx_data = oct(r_ac[2:0]);
                5'd17: tx_data = oct({2'b00, r_ion});
                5'd18: tx_data = 8'h0D;
                5'd19: tx_data = 8'h0A;
                default: tx_data = 8'h20;
            endcase
        end
    end

    assign tx_valid = (state == S_DUMP_TX);
    assign busy     = (state == S_ARMED) || (state == S_POST)
                      || (state == S_DUMP_RD) || (state == S_DUMP_TX);
    assign done     = (state == S_DONE);

endmodule

// File: tb/tb_pdp8_trace.sv
// Directed bench for pdp8_trace: capture, wrap, trigger/post count,
// dump back-pressure and reset during a dump.
module tb_pdp8_trace;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        arm, disarm, fetch_strobe;
    logic [11:0] pc, ir, ac, trig_pc;
    logic        l, ion, trig_en, dump_req, tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid, busy, done, triggered;
    logic [8:0]  count;

    int n_checks = 0;
    int n_err = 0;
    logic [7:0] byte_q [$];

    always #5 clk = ~clk;

    pdp8_trace #(.ADDR_W(8), .POST_CNT(4)) dut (
        .clk(clk), .reset_n(reset_n), .arm(arm), .disarm(disarm),
        .fetch_strobe(fetch_strobe), .pc(pc), .ir(ir), .l(l), .ac(ac),
        .ion(ion), .trig_en(trig_en), .trig_pc(trig_pc),
        .dump_req(dump_req), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done),
        .triggered(triggered), .count(count)
    );

    task automatic check(input string tag, input logic [159:0] got,
                         input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [159:0] exp_line(
        input logic [11:0] p, input logic [11:0] i, input logic ll,
        input logic [11:0] a, input logic io);
        string s;
        logic [159:0] v;
        s = $sformatf("%04o %04o %0d %04o %0d\r\n", p, i, ll, a, io);
        v = '0;
        for (int k = 0; k < 20 && k < s.len(); k++)
            v[159-8*k -: 8] = s[k];
        return v;
    endfunction

    function automatic logic [159:0] got_line(input int n);
        logic [159:0] v;
        v = '0;
        for (int k = 0; k < 20; k++)
            if (20*n + k < byte_q.size())
                v[159-8*k -: 8] = byte_q[20*n + k];
        return v;
    endfunction

    task automatic pulse_arm();
        @(negedge clk) arm = 1'b1;
        @(negedge clk) arm = 1'b0;
    endtask

    task automatic pulse_disarm();
        @(negedge clk) disarm = 1'b1;
        @(negedge clk) disarm = 1'b0;
    endtask

    task automatic pulse_dump();
        @(negedge clk) dump_req = 1'b1;
        @(negedge clk) dump_req = 1'b0;
    endtask

    task automatic strobe(input logic [11:0] p, input logic [11:0] i,
                          input logic ll, input logic [11:0] a,
                          input logic io);
        @(negedge clk);
        pc = p; ir = i; l = ll; ac = a; ion = io;
        fetch_strobe = 1'b1;
        @(negedge clk) fetch_strobe = 1'b0;
    endtask

    // Called on a negedge right after the dump_req pulse.
    task automatic collect(input int stall_at, input int abort_at);
        int cyc;
        bit stalled;
        bit aborted;
        cyc = 0;
        stalled = 0;
        aborted = 0;
        byte_q.delete();
        tx_ready = 1'b1;
        while (busy && cyc < 20000 && !aborted) begin
            if (tx_valid && byte_q.size() == abort_at) begin
                reset_n = 1'b0;
                #1;
                check("abort_tx_valid", tx_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_count", count, 0);
                check("abort_done", done, 0);
                aborted = 1;
            end else begin
                if (tx_valid && byte_q.size() == stall_at && !stalled) begin
                    stalled = 1;
                    tx_ready = 1'b0;
                    for (int s = 0; s < 5; s++) begin
                        check("stall_valid", tx_valid, 1);
                        check("stall_data", tx_data, 8'h30);
                        @(negedge clk);
                    end
                    tx_ready = 1'b1;
                end
                if (tx_valid) byte_q.push_back(tx_data);
                @(negedge clk);
                cyc++;
            end
        end
        check("dump_bound", cyc < 20000, 1);
    endtask

    initial begin
        reset_n = 1'b0;
        arm = 0; disarm = 0; fetch_strobe = 0; dump_req = 0;
        pc = 0; ir = 0; l = 0; ac = 0; ion = 0;
        trig_en = 0; trig_pc = 0; tx_ready = 1;

        // reset, including an arm held across an active edge
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_trig", triggered, 0);
        check("rst_count", count, 0);
        check("rst_tx_data", tx_data, 0);
        @(negedge clk) reset_n = 1'b1;

        // three fetches then dump
        pulse_arm();
        check("armed_busy", busy, 1);
        strobe(12'o0200, 12'o7200, 0, 12'o0000, 0);
        strobe(12'o0201, 12'o7001, 0, 12'o0001, 0);
        strobe(12'o0202, 12'o5201, 0, 12'o0001, 0);
        pulse_disarm();
        check("t2_done", done, 1);
        check("t2_count", count, 3);
        pulse_dump();
        collect(-1, -1);
        check("t2_bytes", byte_q.size(), 60);
        check("t2_line0", got_line(0),
              exp_line(12'o0200, 12'o7200, 0, 12'o0000, 0));
        check("t2_line1", got_line(1),
              exp_line(12'o0201, 12'o7001, 0, 12'o0001, 0));
        check("t2_line2", got_line(2),
              exp_line(12'o0202, 12'o5201, 0, 12'o0001, 0));
        check("t2_idle_busy", busy, 0);
        check("t2_idle_done", done, 0);
        check("t2_count_kept", count, 3);
        // replay from IDLE
        pulse_dump();
        collect(-1, -1);
        check("t2_replay_bytes", byte_q.size(), 60);
        check("t2_replay_line2", got_line(2),
              exp_line(12'o0202, 12'o5201, 0, 12'o0001, 0));

        // wrap-around: 300 fetches into a 256-deep buffer
        pulse_arm();
        check("t3_cleared", count, 0);
        for (int j = 0; j < 300; j++) begin
            logic [11:0] jj;
            jj = 12'(j);
            strobe(jj, 12'(j * 5), jj[0], ~jj, jj[1]);
        end
        check("t3_count", count, 256);
        pulse_disarm();
        pulse_dump();
        collect(-1, -1);
        check("t3_bytes", byte_q.size(), 5120);
        for (int i = 0; i < 256; i++) begin
            logic [11:0] jj;
            jj = 12'(44 + i);
            check($sformatf("t3_line%0d", i), got_line(i),
                  exp_line(jj, 12'((44 + i) * 5), jj[0], ~jj, jj[1]));
        end

        // trigger at 0205 with four post-trigger records
        trig_en = 1'b1;
        trig_pc = 12'o0205;
        pulse_arm();
        check("t4_trig_clr", triggered, 0);
        for (int i = 0; i <= 16; i++) begin
            strobe(12'o0200 + 12'(i), 12'(i), 0, 12'o0000, 1);
            if (i == 4) check("t4_trig_before", triggered, 0);
            if (i == 5) check("t4_trig_at", triggered, 1);
            if (i == 8) check("t4_done_before", done, 0);
            if (i == 9) check("t4_done_at", done, 1);
        end
        check("t4_count", count, 10);
        check("t4_done_end", done, 1);
        trig_en = 1'b0;

        // dump with back-pressure on byte 3
        pulse_dump();
        collect(3, -1);
        check("t5_bytes", byte_q.size(), 200);
        for (int i = 0; i < 10; i++)
            check($sformatf("t5_line%0d", i), got_line(i),
                  exp_line(12'o0200 + 12'(i), 12'(i), 0, 12'o0000, 1));

        // reset during a dump, then a fresh capture
        pulse_dump();
        collect(-1, 7);
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
        check("t6_idle", busy, 0);
        pulse_arm();
        strobe(12'o1234, 12'o4321, 1, 12'o7777, 1);
        strobe(12'o0007, 12'o0070, 0, 12'o0700, 0);
        pulse_disarm();
        check("t6_count", count, 2);
        pulse_dump();
        collect(-1, -1);
        check("t6_bytes", byte_q.size(), 40);
        check("t6_line0", got_line(0),
              exp_line(12'o1234, 12'o4321, 1, 12'o7777, 1));
        check("t6_line1", got_line(1),
              exp_line(12'o0007, 12'o0070, 0, 12'o0700, 0));

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
